// File: rtl/tilt_step_scheduler.sv
// Board-tilt step scheduler: debounced, auto-repeating step pulses per axis
// plus a tilt-feedback re-level sequence that walks each axis back to zero.
module tilt_step_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int DEB_TICKS    = 10,
  parameter int HOLD_TICKS   = 300,
  parameter int REPEAT_TICKS = 20,
  parameter int CENTER_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  btn,
  input  logic        center,
  input  logic [10:0] tilt_x,
  input  logic [10:0] tilt_y,
  output logic [3:0]  slope,
  output logic        busy_x,
  output logic        busy_y
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = 16;

  localparam logic [TW-1:0] TICK_END = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DEB_END  = CW'(DEB_TICKS - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] REP_END  = CW'(REPEAT_TICKS - 1);
  localparam logic [CW-1:0] CEN_END  = CW'(CENTER_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, HOLD, REPEAT, CENTER
  } state_t;

  logic [3:0]    btn_m;
  logic [3:0]    btn_s;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [1:0]    busy_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_m <= '0;
      btn_s <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // Free-running tick divider, independent of enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign tick = (tcnt == TICK_END);

  for (genvar a = 0; a < 2; a++) begin : g_axis
    state_t          st;
    state_t          st_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [1:0]      ld;
    logic [1:0]      ld_n;
    logic            pend;
    logic            pend_n;
    logic [1:0]      step;
    logic [1:0]      sq;
    logic [1:0]      dir;
    logic            dv;
    logic [10:0]     tilt;
    logic            tz;

    assign dir  = btn_s[2*a +: 2];
    assign dv   = ^dir;
    assign tilt = (a == 0) ? tilt_x : tilt_y;
    assign tz   = (tilt == '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st   <= IDLE;
        cnt  <= '0;
        ld   <= '0;
        pend <= 1'b0;
        sq   <= '0;
      end else begin
        st   <= st_n;
        cnt  <= cnt_n;
        ld   <= ld_n;
        pend <= pend_n;
        sq   <= step;
      end
    end

    // Direction changes are evaluated before the tick, so they
    // swallow any step that was due in the same cycle.
    always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      ld_n   = ld;
      pend_n = pend;
      step   = 2'b00;
      unique case (st)
        IDLE: begin
          if (dv) begin
            st_n  = DEBOUNCE;
            ld_n  = dir;
            cnt_n = '0;
          end else if (pend) begin
            pend_n = 1'b0;
            cnt_n  = '0;
            if (!tz) st_n = CENTER;
          end
        end
        DEBOUNCE: begin
          if (dir != ld) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == DEB_END) begin
              step  = ld;
              st_n  = HOLD;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (dir != ld) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == HOLD_END) begin
              step  = ld;
              st_n  = REPEAT;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        REPEAT: begin
          if (dir != ld) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == REP_END) begin
              step  = ld;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        CENTER: begin
          if (dv) begin
            st_n  = DEBOUNCE;
            ld_n  = dir;
            cnt_n = '0;
          end else if (tick) begin
            if (cnt == CEN_END) begin
              cnt_n = '0;
              if (tz) begin
                st_n = IDLE;
              end else begin
                step = tilt[10] ? 2'b01 : 2'b10;
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = '0;
        end
      endcase
      if (center && st != CENTER) pend_n = 1'b1;
      if (!enable) begin
        st_n   = IDLE;
        cnt_n  = '0;
        pend_n = 1'b0;
        step   = 2'b00;
      end
    end

    assign slope[2*a +: 2] = sq;
    assign busy_v[a]       = (st == CENTER);
  end

  assign busy_x = busy_v[0];
  assign busy_y = busy_v[1];

endmodule

// File: tb/tb_tilt_step_scheduler.sv
// Directed bench for tilt_step_scheduler: timed event tables drive the
// buttons, a small accumulator model closes the tilt loop.
module tb_tilt_step_scheduler;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic              center = 1'b0;
  logic [3:0]        btn = 4'b0000;
  logic signed [10:0] tilt_x;
  logic signed [10:0] tilt_y;
  logic [3:0]        slope;
  logic              busy_x;
  logic              busy_y;

  logic              load = 1'b0;
  logic signed [10:0] lx = '0;
  logic signed [10:0] ly = '0;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    int              cyc;
    logic [3:0]      btn;
    logic            en;
    logic            ctr;
    logic            ld;
    logic signed [10:0] x;
    logic signed [10:0] y;
  } ev_t;

  typedef struct {
    int         cyc;
    logic [3:0] slope;
  } pulse_t;

  ev_t    evq[$];
  pulse_t pq[$];
  int bx_lo, bx_hi, by_lo, by_hi;

  tilt_step_scheduler #(
    .TICK_DIV(4), .DEB_TICKS(2), .HOLD_TICKS(5),
    .REPEAT_TICKS(3), .CENTER_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn(btn),
    .center(center), .tilt_x(tilt_x), .tilt_y(tilt_y),
    .slope(slope), .busy_x(busy_x), .busy_y(busy_y)
  );

  always #5 clk = ~clk;

  // cyc = posedges since reset release, so tick edges are cyc%4==0
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic signed [10:0] nxt(
    input logic signed [10:0] t, input logic [1:0] s);
    if (s == 2'b01 && t != 11'sd1023) return t + 11'sd1;
    if (s == 2'b10 && t != -11'sd1023) return t - 11'sd1;
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tilt_x <= '0;
      tilt_y <= '0;
    end else if (load) begin
      tilt_x <= lx;
      tilt_y <= ly;
    end else begin
      tilt_x <= nxt(tilt_x, slope[1:0]);
      tilt_y <= nxt(tilt_y, slope[3:2]);
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic ev(input int c, input logic [3:0] b, input logic e,
                    input logic ct, input logic l,
                    input logic signed [10:0] x,
                    input logic signed [10:0] y);
    ev_t r;
    r.cyc = c; r.btn = b; r.en = e; r.ctr = ct;
    r.ld = l; r.x = x; r.y = y;
    evq.push_back(r);
  endtask

  task automatic pulse(input int c, input logic [3:0] s);
    pulse_t p;
    p.cyc = c; p.slope = s;
    pq.push_back(p);
  endtask

  function automatic logic [3:0] exp_slope(input int c);
    foreach (pq[i]) if (pq[i].cyc == c) return pq[i].slope;
    return 4'b0000;
  endfunction

  task automatic clear_tables();
    evq.delete();
    pq.delete();
    bx_lo = 1; bx_hi = 0;
    by_lo = 1; by_hi = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn = 4'b0000; center = 1'b0;
    enable = 1'b1; load = 1'b0;
    clear_tables();
    @(negedge clk);
    @(negedge clk);
    chk("rst_slope", {12'd0, slope}, 16'd0);
    chk("rst_busy", {14'd0, busy_y, busy_x}, 16'd0);
    rst = 1'b0;
  endtask

  task automatic run(input int last);
    for (int k = 0; k < 400 && cyc < last; k++) begin
      @(negedge clk);
      center = 1'b0;
      load   = 1'b0;
      chk("slope", {12'd0, slope}, {12'd0, exp_slope(cyc)});
      chk("busy_x", {15'd0, busy_x},
          {15'd0, (cyc >= bx_lo && cyc <= bx_hi)});
      chk("busy_y", {15'd0, busy_y},
          {15'd0, (cyc >= by_lo && cyc <= by_hi)});
      foreach (evq[i]) if (evq[i].cyc == cyc) begin
        btn = evq[i].btn; enable = evq[i].en;
        center = evq[i].ctr; load = evq[i].ld;
        lx = evq[i].x; ly = evq[i].y;
      end
    end
    if (cyc < last) chk("run_timeout", 16'(cyc), 16'(last));
  endtask

  initial begin
    // Hold x+: steps at ticks 2, 7, 10, 13, none after release
    do_reset();
    ev(10, 4'b0001, 1, 0, 0, 0, 0);
    ev(70, 4'b0000, 1, 0, 0, 0, 0);
    pulse(20, 4'b0001); pulse(40, 4'b0001);
    pulse(52, 4'b0001); pulse(64, 4'b0001);
    run(80);

    // One-cycle drop restarts debounce; both x buttons give nothing
    do_reset();
    ev(10, 4'b0001, 1, 0, 0, 0, 0);
    ev(14, 4'b0000, 1, 0, 0, 0, 0);
    ev(15, 4'b0001, 1, 0, 0, 0, 0);
    ev(26, 4'b0000, 1, 0, 0, 0, 0);
    ev(30, 4'b0011, 1, 0, 0, 0, 0);
    ev(74, 4'b0000, 1, 0, 0, 0, 0);
    pulse(24, 4'b0001);
    run(80);

    // Re-level from x=+3, y=-2
    do_reset();
    ev(18, 4'b0000, 1, 0, 1, 11'sd3, -11'sd2);
    ev(20, 4'b0000, 1, 1, 0, 0, 0);
    pulse(24, 4'b0110); pulse(28, 4'b0110); pulse(32, 4'b0010);
    bx_lo = 22; bx_hi = 35;
    by_lo = 22; by_hi = 31;
    run(40);
    chk("relevel_tilt_x", 16'(tilt_x), 16'd0);
    chk("relevel_tilt_y", 16'(tilt_y), 16'd0);

    // x- press aborts centering on a tick edge
    do_reset();
    ev(18, 4'b0000, 1, 0, 1, 11'sd5, 11'sd0);
    ev(20, 4'b0000, 1, 1, 0, 0, 0);
    ev(29, 4'b0010, 1, 0, 0, 0, 0);
    ev(74, 4'b0000, 1, 0, 0, 0, 0);
    pulse(24, 4'b0010); pulse(28, 4'b0010);
    pulse(40, 4'b0010); pulse(60, 4'b0010); pulse(72, 4'b0010);
    bx_lo = 22; bx_hi = 31;
    run(88);
    chk("abort_tilt_x", 16'(tilt_x), 16'd0);

    // Disabled: held y- and center are ignored
    do_reset();
    ev(8,  4'b0000, 0, 0, 1, 11'sd5, 11'sd0);
    ev(10, 4'b1000, 0, 0, 0, 0, 0);
    ev(20, 4'b1000, 0, 1, 0, 0, 0);
    ev(41, 4'b1000, 1, 0, 0, 0, 0);
    ev(56, 4'b0000, 1, 0, 0, 0, 0);
    pulse(48, 4'b1000);
    run(70);

    // Async reset in REPEAT, then a fresh debounce
    do_reset();
    ev(10, 4'b0001, 1, 0, 0, 0, 0);
    pulse(20, 4'b0001); pulse(40, 4'b0001); pulse(52, 4'b0001);
    run(52);
    rst = 1'b1;
    #1;
    chk("async_rst_slope", {12'd0, slope}, 16'd0);
    chk("async_rst_busy", {14'd0, busy_y, busy_x}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    clear_tables();
    rst = 1'b0;
    pulse(8, 4'b0001);
    run(10);
    btn = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
